// File: rtl/sprite_sched_pkg.sv
// Shared definitions for the sprite scheduler: state encodings, the default
// erase colour and helpers for addressing fields of the packed object buses.
package sprite_sched_pkg;

    typedef enum logic [2:0] {
        ST_LATCH = 3'd0,
        ST_PLOT  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ERASE = 3'd3,
        ST_MOVE  = 3'd4,
        ST_CHECK = 3'd5
    } state_e;

    localparam int BG_COLOUR_DEFAULT = 0;

    // Bit offset of object idx inside a packed bus of width-bit fields.
    function automatic int field_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sprite_raster.sv
// Pixel walker for one sprite rectangle: px runs 0..w-1 (inner), py runs
// 0..h-1 (outer). A non-drawable sprite is walked as a single skip cycle.
module sprite_raster #(
    parameter int SZ_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            step,
    input  logic            active,
    input  logic [SZ_W-1:0] w,
    input  logic [SZ_W-1:0] h,
    output logic [SZ_W-1:0] px,
    output logic [SZ_W-1:0] py,
    output logic            drawable,
    output logic            last
);

    logic [SZ_W-1:0] px_q, px_d;
    logic [SZ_W-1:0] py_q, py_d;

    assign drawable = active && (w != '0) && (h != '0);
    // A skipped sprite occupies exactly one cycle, so it is always its own last.
    assign last     = !drawable || ((px_q == w - SZ_W'(1)) && (py_q == h - SZ_W'(1)));
    assign px       = px_q;
    assign py       = py_q;

    // Next pixel position; counters return to zero after each sprite.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        px_d = px_q;
        py_d = py_q;
        if (start) begin
            px_d = '0;
            py_d = '0;
        end else if (step) begin
            if (last) begin
                px_d = '0;
                py_d = '0;
            end else if (px_q == w - SZ_W'(1)) begin
                px_d = '0;
                py_d = py_q + SZ_W'(1);
            end else begin
                px_d = px_q + SZ_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so all flops sample together.
        if (reset) begin
            px_q <= '0;
            py_q <= '0;
        end else begin
            px_q <= px_d;
            py_q <= py_d;
        end
    end

endmodule

// File: rtl/sprite_scheduler.sv
// Draw / erase / move / collide controller for NUM_OBJ rectangular sprites
// feeding the VGA adapter write port. Object 0 is the player.
// Optional: define SPRITE_SCHED_GAMEOVER_EN to make a collision latch a
// sticky gameover flag that freezes the loop in WAIT until reset.
module sprite_scheduler
    import sprite_sched_pkg::*;
#(
    parameter int NUM_OBJ   = 4,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int SZ_W      = 6,
    parameter int COLOUR_W  = 3,
    parameter int BG_COLOUR = BG_COLOUR_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         want_to_move,
    input  logic [NUM_OBJ*X_W-1:0]       obj_x,
    input  logic [NUM_OBJ*Y_W-1:0]       obj_y,
    input  logic [NUM_OBJ*SZ_W-1:0]      obj_w,
    input  logic [NUM_OBJ*SZ_W-1:0]      obj_h,
    input  logic [NUM_OBJ*COLOUR_W-1:0]  obj_colour,
    input  logic [NUM_OBJ-1:0]           obj_active,
    output logic                         plot,
    output logic [X_W-1:0]               x_out,
    output logic [Y_W-1:0]               y_out,
    output logic [COLOUR_W-1:0]          colour_out,
    output logic                         can_move,
    output logic [NUM_OBJ-1:0]           hit,
    output logic                         gameover,
    output logic [2:0]                   state,
    output logic [$clog2(NUM_OBJ)-1:0]   cur_obj
);

    localparam int OBJ_W = $clog2(NUM_OBJ);

    // Live object fields unpacked from the buses.
    logic [X_W-1:0]      live_x      [NUM_OBJ];
    logic [Y_W-1:0]      live_y      [NUM_OBJ];
    logic [SZ_W-1:0]     live_w      [NUM_OBJ];
    logic [SZ_W-1:0]     live_h      [NUM_OBJ];
    logic [COLOUR_W-1:0] live_colour [NUM_OBJ];

    for (genvar g = 0; g < NUM_OBJ; g++) begin : g_unpack
        assign live_x[g]      = obj_x[field_lsb(g, X_W) +: X_W];
        assign live_y[g]      = obj_y[field_lsb(g, Y_W) +: Y_W];
        assign live_w[g]      = obj_w[field_lsb(g, SZ_W) +: SZ_W];
        assign live_h[g]      = obj_h[field_lsb(g, SZ_W) +: SZ_W];
        assign live_colour[g] = obj_colour[field_lsb(g, COLOUR_W) +: COLOUR_W];
    end

    // Control state.
    state_e              state_q, state_d;
    logic [OBJ_W-1:0]    cur_obj_q, cur_obj_d;
    logic [NUM_OBJ-1:0]  hit_q, hit_d;
    logic                gameover_q, gameover_d;
    logic                can_move_q, can_move_d;

    // Shadow rectangles: what PLOT drew is exactly what ERASE removes.
    logic [X_W-1:0]      sx_q [NUM_OBJ], sx_d [NUM_OBJ];
    logic [Y_W-1:0]      sy_q [NUM_OBJ], sy_d [NUM_OBJ];
    logic [SZ_W-1:0]     sw_q [NUM_OBJ], sw_d [NUM_OBJ];
    logic [SZ_W-1:0]     sh_q [NUM_OBJ], sh_d [NUM_OBJ];
    logic [NUM_OBJ-1:0]  sact_q, sact_d;

    // Shared raster walker.
    logic            walking;
    logic [SZ_W-1:0] px, py;
    logic            drawable, last;

    assign walking = (state_q == ST_PLOT) || (state_q == ST_ERASE);

    sprite_raster #(.SZ_W(SZ_W)) u_raster (
        .clock    (clock),
        .reset    (reset),
        .start    (!walking),
        .step     (walking),
        .active   (sact_q[cur_obj_q]),
        .w        (sw_q[cur_obj_q]),
        .h        (sh_q[cur_obj_q]),
        .px       (px),
        .py       (py),
        .drawable (drawable),
        .last     (last)
    );

    // Pixel outputs; forced to zero when not plotting so reset shows zeros.
    assign plot       = walking && drawable;
    assign x_out      = plot ? sx_q[cur_obj_q] + X_W'(px) : '0;
    assign y_out      = plot ? sy_q[cur_obj_q] + Y_W'(py) : '0;
    assign colour_out = !plot ? '0
                      : (state_q == ST_ERASE) ? COLOUR_W'(BG_COLOUR)
                      : live_colour[cur_obj_q];

    // Collision of live object 0 against every other object; widened sums never wrap.
    logic [NUM_OBJ-1:0] overlap;
    logic               obj0_drawable;

    assign obj0_drawable = obj_active[0] && (live_w[0] != '0) && (live_h[0] != '0);
    assign overlap[0]    = 1'b0;

    for (genvar g = 1; g < NUM_OBJ; g++) begin : g_collide
        logic [X_W:0] x0, xi, x0_end, xi_end;
        logic [Y_W:0] y0, yi, y0_end, yi_end;
        logic         obji_drawable;

        assign x0     = {1'b0, live_x[0]};
        assign xi     = {1'b0, live_x[g]};
        assign y0     = {1'b0, live_y[0]};
        assign yi     = {1'b0, live_y[g]};
        assign x0_end = x0 + (X_W+1)'(live_w[0]);
        assign xi_end = xi + (X_W+1)'(live_w[g]);
        assign y0_end = y0 + (Y_W+1)'(live_h[0]);
        assign yi_end = yi + (Y_W+1)'(live_h[g]);

        assign obji_drawable = obj_active[g] && (live_w[g] != '0) && (live_h[g] != '0);
        assign overlap[g]    = obj0_drawable && obji_drawable &&
                               (x0 < xi_end) && (xi < x0_end) &&
                               (y0 < yi_end) && (yi < y0_end);
    end

    // Next-state and next-output logic of the frame sequencer.
    always_comb begin
        state_d    = state_q;
        cur_obj_d  = cur_obj_q;
        hit_d      = hit_q;
        gameover_d = gameover_q;
        can_move_d = 1'b0;
        sx_d       = sx_q;
        sy_d       = sy_q;
        sw_d       = sw_q;
        sh_d       = sh_q;
        sact_d     = sact_q;

        case (state_q)
            ST_LATCH: begin
                for (int i = 0; i < NUM_OBJ; i++) begin
                    sx_d[i] = live_x[i];
                    sy_d[i] = live_y[i];
                    sw_d[i] = live_w[i];
                    sh_d[i] = live_h[i];
                end
                sact_d    = obj_active;
                cur_obj_d = '0;
                state_d   = ST_PLOT;
            end
            ST_PLOT, ST_ERASE: begin
                if (last) begin
                    if (cur_obj_q == OBJ_W'(NUM_OBJ - 1)) begin
                        cur_obj_d = '0;
                        if (state_q == ST_PLOT) begin
                            state_d = ST_WAIT;
                        end else begin
                            state_d    = ST_MOVE;
                            can_move_d = 1'b1;
                        end
                    end else begin
                        cur_obj_d = cur_obj_q + OBJ_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (want_to_move && !gameover_q) begin
                    state_d = ST_ERASE;
                end
            end
            ST_MOVE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                hit_d = overlap;
`ifdef SPRITE_SCHED_GAMEOVER_EN
                gameover_d = gameover_q || (overlap != '0);
`else
                gameover_d = 1'b0;
`endif
                state_d = ST_LATCH;
            end
            default: begin
                state_d = ST_LATCH;
            end
        endcase
    end

    // Sequencer registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_LATCH;
            cur_obj_q  <= '0;
            hit_q      <= '0;
            gameover_q <= 1'b0;
            can_move_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_obj_q  <= cur_obj_d;
            hit_q      <= hit_d;
            gameover_q <= gameover_d;
            can_move_q <= can_move_d;
        end
    end

    // Shadow registers.
    always_ff @(posedge clock) begin
        // NOTE: shadows are not reset; LATCH always reloads them before PLOT reads them.
        sx_q   <= sx_d;
        sy_q   <= sy_d;
        sw_q   <= sw_d;
        sh_q   <= sh_d;
        sact_q <= sact_d;
    end

    assign state    = state_q;
    assign cur_obj  = cur_obj_q;
    assign hit      = hit_q;
    assign gameover = gameover_q;
    assign can_move = can_move_q;

endmodule
